mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory of the multicycle RISC-V core between two requesters: the instruction-fetch path (fetch state, IFen/fetchEN) and the load/store path (LD_MEM/S_MEM, bytesel/memWrite).
- Arbitrates between the two requesters and sequences each access through a fixed-latency memory.
- For data accesses, generates byte-lane write strobes, aligns store data, and extracts and sign/zero-extends load data.
- Sits between the control unit/datapath and the memory macro.

Parameters:
ADDR_W, 32, byte-address width of both requesters
MEM_LAT, 1, memory read latency in cycles, counted from the mem_en cycle to the mem_rdata-valid cycle; legal range 1..7

Ports:
clk  in  1  core clock, rising edge
rst  in  1  asynchronous, active-low reset (0 = reset)
if_req  in  1  fetch request; held high until if_gnt
if_addr  in  ADDR_W  fetch byte address; bits [1:0] ignored
if_gnt  out  1  fetch request accepted this cycle
if_rvalid  out  1  one-cycle pulse: if_rdata valid
if_rdata  out  32  fetched instruction word
d_req  in  1  data request; held high until d_gnt
d_we  in  1  1 = store, 0 = load
d_size  in  3  RISC-V func3: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
d_addr  in  ADDR_W  data byte address
d_wdata  in  32  store data, right-justified
d_gnt  out  1  data request accepted this cycle
d_rvalid  out  1  one-cycle pulse: load data valid, or store/error completion
d_rdata  out  32  extended load data; 0 for stores and errors
d_err  out  1  qualifies d_rvalid: misaligned access or illegal size
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_wstrb  out  4  byte-lane write strobes
mem_addr  out  ADDR_W-2  word address
mem_wdata  out  32  lane-aligned store data
mem_rdata  in  32  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0; FSM to IDLE; latency counter 0; last_grant = FETCH, so data wins the first tie.
- Reset mid-operation aborts the access. No rvalid is issued for the aborted access.
- FSM states and transitions:
  - IDLE: grants at most one request per cycle.
  - ACCESS: exactly one cycle, mem_en=1.
  - WAIT: present only when MEM_LAT>1; holds for MEM_LAT-1 cycles.
  - CAPTURE: registers mem_rdata.
  - RESP: exactly one cycle; asserts if_rvalid or d_rvalid, then returns to IDLE.
- Arbitration in IDLE:
  - Only one request pending: grant it.
  - Both pending: grant the requester opposite to last_grant (round-robin).
  - gnt is combinational in IDLE and is 0 in all other states.
- On grant, latch addr/we/size/wdata and the owner, and update last_grant.
- Timing: grant at cycle T, mem_en at T+1, mem_rdata sampled at T+1+MEM_LAT, rvalid at T+2+MEM_LAT. With MEM_LAT=1, rvalid is at T+3. Back-to-back grants are no closer than every MEM_LAT+3 cycles.
- Fetch accesses: always word reads; mem_wstrb=0000, mem_we=0.
- Stores:
  - mem_we=1 in ACCESS.
  - SB: mem_wdata={4{wdata[7:0]}}, mem_wstrb=0001<<addr[1:0].
  - SH: mem_wdata={2{wdata[15:0]}}, mem_wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1).
  - SW: mem_wstrb=1111.
  - A store still walks ACCESS/WAIT/CAPTURE/RESP; d_rvalid=1, d_rdata=0.
- Loads: select lane by addr[1:0] (byte) or addr[1] (half).
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
  - LW: pass the word through unchanged.
- Errors:
  - Misaligned: H with addr[0]=1, or W with addr[1:0]≠00.
  - Illegal size: 011, 110, 111, and any store with size ≥100.
  - On error: grant normally, skip memory (mem_en stays 0), go directly to RESP at T+1 with d_rvalid=1, d_err=1, d_rdata=0.
- Requests: a requester must hold addr/data stable until gnt. Deasserting req before gnt is legal and causes no action. Requests while busy are not granted.
- mem_* outputs are 0 outside ACCESS.

Decomposition:
- Package riscv_mem_pkg:
  - func3 size localparams (SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU).
  - FSM state encoding.
  - Owner encoding (OWN_FETCH, OWN_DATA).
- Combinational sub-module mem_lane_align: computes mem_wstrb, mem_wdata, the load-extend result and the misalign/illegal flag. It is reused by a future cache.

Test Plan:
1. Reset: rst=0 while d_req=1 in WAIT -> all outputs 0 immediately; after rst=1, no d_rvalid is issued for the aborted access.
2. Fetch, MEM_LAT=1: if_req with if_addr=0x0000_0104 -> if_gnt at T; mem_en=1 and mem_addr=0x41 at T+1; if_rvalid at T+3 with if_rdata = the mem_rdata presented at T+2.
3. Contention after reset: if_req and d_req both high -> d_gnt first; if_gnt at the next IDLE. Then both high again -> data granted (alternation).
4. Loads: mem word 0x80FF_7F01. LB @addr 0x…1 -> 0x0000_007F. LB @0x…2 -> 0xFFFF_FFFF. LBU @0x…3 -> 0x0000_0080. LH @0x…2 -> 0xFFFF_80FF.
5. Stores: SB d_wdata=0x0000_00AB @0x…3 -> mem_wstrb=1000, mem_wdata=0xABAB_ABAB. SH @0x…2 -> wstrb 1100. SW -> wstrb 1111.
6. Errors: LW @0x…2, or SH @0x…1 -> mem_en never asserted; d_rvalid=1 and d_err=1 at T+1. d_size=011 -> same response.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// Shared constants for the unified instruction/data memory port.
package riscv_mem_pkg;

  // RISC-V func3 access sizes
  localparam logic [2:0] SZ_B  = 3'b000;
  localparam logic [2:0] SZ_H  = 3'b001;
  localparam logic [2:0] SZ_W  = 3'b010;
  localparam logic [2:0] SZ_BU = 3'b100;
  localparam logic [2:0] SZ_HU = 3'b101;

  // Arbiter FSM encoding
  localparam int unsigned STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
  localparam logic [STATE_W-1:0] ST_ACCESS  = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT    = 3'd2;
  localparam logic [STATE_W-1:0] ST_CAPTURE = 3'd3;
  localparam logic [STATE_W-1:0] ST_RESP    = 3'd4;

  // Access owner / last-grant encoding
  localparam logic OWN_FETCH = 1'b0;
  localparam logic OWN_DATA  = 1'b1;

  // Latency counter width, enough for MEM_LAT up to 7
  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane handling for a 32-bit memory: store strobes/replication,
// load lane select with sign/zero extension, and access legality.
module mem_lane_align
  import riscv_mem_pkg::*;
(
  input  logic [1:0]  addr_lo_i,
  input  logic [2:0]  size_i,
  input  logic        we_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  wstrb_c_o,
  output logic [31:0] wdata_c_o,
  output logic [31:0] rdata_c_o,
  output logic        err_c_o
);

  logic        illegal_c;
  logic        misalign_c;
  logic [7:0]  byte_c;
  logic [15:0] half_c;

  // Reserved func3 codes, unsigned stores, and misaligned halves/words
  always_comb begin
    illegal_c  = (size_i == 3'b011) || (size_i == 3'b110) || (size_i == 3'b111) ||
                 (we_i && size_i[2]);
    misalign_c = ((size_i[1:0] == 2'b01) && addr_lo_i[0]) ||
                 ((size_i == SZ_W) && (addr_lo_i != 2'b00));
    err_c_o    = illegal_c || misalign_c;
  end

  // Store data is replicated across lanes; strobes pick the target lanes
  always_comb begin
    wstrb_c_o = 4'b0000;
    wdata_c_o = wdata_i;
    case (size_i)
      SZ_B: begin
        wdata_c_o = {4{wdata_i[7:0]}};
        wstrb_c_o = 4'b0001 << addr_lo_i;
      end
      SZ_H: begin
        wdata_c_o = {2{wdata_i[15:0]}};
        wstrb_c_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
      end
      SZ_W:    wstrb_c_o = 4'b1111;
      default: wstrb_c_o = 4'b0000;
    endcase
    if (!we_i || err_c_o) begin
      wstrb_c_o = 4'b0000;
    end
  end

  // Load lane select and extension
  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_c = rdata_i[7:0];
      2'd1:    byte_c = rdata_i[15:8];
      2'd2:    byte_c = rdata_i[23:16];
      default: byte_c = rdata_i[31:24];
    endcase
    half_c = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    case (size_i)
      SZ_B:    rdata_c_o = {{24{byte_c[7]}}, byte_c};
      SZ_BU:   rdata_c_o = {24'd0, byte_c};
      SZ_H:    rdata_c_o = {{16{half_c[15]}}, half_c};
      SZ_HU:   rdata_c_o = {16'd0, half_c};
      SZ_W:    rdata_c_o = rdata_i;
      default: rdata_c_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency memory port between
// instruction fetch and load/store, with byte-lane alignment for data.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [2:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic              d_gnt,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-3:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);

  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT - 2);

  logic [STATE_W-1:0] state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               own_q, own_d;
  logic               last_q, last_d;
  logic [1:0]         addr_lo_q, addr_lo_d;
  logic [2:0]         size_q, size_d;
  logic               we_q, we_d;

  logic               if_rvalid_q, if_rvalid_d;
  logic [31:0]        if_rdata_q, if_rdata_d;
  logic               d_rvalid_q, d_rvalid_d;
  logic [31:0]        d_rdata_q, d_rdata_d;
  logic               d_err_q, d_err_d;
  logic               mem_en_q, mem_en_d;
  logic               mem_we_q, mem_we_d;
  logic [3:0]         mem_wstrb_q, mem_wstrb_d;
  logic [ADDR_W-3:0]  mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;

  logic               idle_c;
  logic               sel_data_c;
  logic               gnt_any_c;
  logic               if_gnt_c;
  logic               d_gnt_c;
  logic [ADDR_W-1:0]  req_addr_c;
  logic [1:0]         req_lo_c;
  logic [2:0]         req_size_c;
  logic               req_we_c;
  logic [1:0]         al_lo_c;
  logic [2:0]         al_size_c;
  logic               al_we_c;
  logic [3:0]         al_wstrb_c;
  logic [31:0]        al_wdata_c;
  logic [31:0]        al_rdata_c;
  logic               al_err_c;

  // Request selection: data wins when alone or when fetch had the last grant
  always_comb begin
    idle_c     = (state_q == ST_IDLE);
    sel_data_c = d_req && (!if_req || (last_q == OWN_FETCH));
    gnt_any_c  = rst && idle_c && (if_req || d_req);
    d_gnt_c    = gnt_any_c && sel_data_c;
    if_gnt_c   = gnt_any_c && !sel_data_c;
    req_addr_c = sel_data_c ? d_addr : if_addr;
    req_lo_c   = req_addr_c[1:0] & {2{sel_data_c}};
    req_size_c = sel_data_c ? d_size : SZ_W;
    req_we_c   = sel_data_c && d_we;
    al_lo_c    = idle_c ? req_lo_c   : addr_lo_q;
    al_size_c  = idle_c ? req_size_c : size_q;
    al_we_c    = idle_c ? req_we_c   : we_q;
  end

  // Aligner sees the live request in IDLE and the latched access afterwards
  mem_lane_align u_align (
    .addr_lo_i (al_lo_c),
    .size_i    (al_size_c),
    .we_i      (al_we_c),
    .wdata_i   (d_wdata),
    .rdata_i   (mem_rdata),
    .wstrb_c_o (al_wstrb_c),
    .wdata_c_o (al_wdata_c),
    .rdata_c_o (al_rdata_c),
    .err_c_o   (al_err_c)
  );

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    own_d       = own_q;
    last_d      = last_q;
    addr_lo_d   = addr_lo_q;
    size_d      = size_q;
    we_d        = we_q;
    if_rvalid_d = 1'b0;
    if_rdata_d  = 32'd0;
    d_rvalid_d  = 1'b0;
    d_rdata_d   = 32'd0;
    d_err_d     = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_wstrb_d = 4'b0000;
    mem_addr_d  = '0;
    mem_wdata_d = 32'd0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_any_c) begin
          own_d     = sel_data_c ? OWN_DATA : OWN_FETCH;
          last_d    = sel_data_c ? OWN_DATA : OWN_FETCH;
          addr_lo_d = req_lo_c;
          size_d    = req_size_c;
          we_d      = req_we_c;
          if (al_err_c) begin
            state_d    = ST_RESP;
            d_rvalid_d = 1'b1;
            d_err_d    = 1'b1;
          end else begin
            state_d     = ST_ACCESS;
            mem_en_d    = 1'b1;
            mem_we_d    = req_we_c;
            mem_wstrb_d = al_wstrb_c;
            mem_addr_d  = req_addr_c[ADDR_W-1:2];
            mem_wdata_d = req_we_c ? al_wdata_c : 32'd0;
          end
        end
      end
      ST_ACCESS: begin
        if (MEM_LAT > 1) begin
          state_d = ST_WAIT;
          cnt_d   = '0;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_WAIT: begin
        if (cnt_q == LAT_LAST) begin
          state_d = ST_CAPTURE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_CAPTURE: begin
        state_d = ST_RESP;
        if (own_q == OWN_FETCH) begin
          if_rvalid_d = 1'b1;
          if_rdata_d  = mem_rdata;
        end else begin
          d_rvalid_d = 1'b1;
          d_rdata_d  = we_q ? 32'd0 : al_rdata_c;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and output registers; reset aborts any access in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      own_q       <= OWN_FETCH;
      last_q      <= OWN_FETCH;
      addr_lo_q   <= 2'b00;
      size_q      <= 3'b000;
      we_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      if_rdata_q  <= 32'd0;
      d_rvalid_q  <= 1'b0;
      d_rdata_q   <= 32'd0;
      d_err_q     <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_wstrb_q <= 4'b0000;
      mem_addr_q  <= '0;
      mem_wdata_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      own_q       <= own_d;
      last_q      <= last_d;
      addr_lo_q   <= addr_lo_d;
      size_q      <= size_d;
      we_q        <= we_d;
      if_rvalid_q <= if_rvalid_d;
      if_rdata_q  <= if_rdata_d;
      d_rvalid_q  <= d_rvalid_d;
      d_rdata_q   <= d_rdata_d;
      d_err_q     <= d_err_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign if_gnt    = if_gnt_c;
  assign d_gnt     = d_gnt_c;
  assign if_rvalid = if_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign d_rvalid  = d_rvalid_q;
  assign d_rdata   = d_rdata_q;
  assign d_err     = d_err_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
